// File: rtl/sm_add_pipe.sv
// Two-stage pipelined sign-magnitude adder/subtractor with valid/ready on both sides.
// Build option SM_ADD_PIPE_SAT_EN: saturate the magnitude on overflow instead of wrapping.
module sm_add_pipe #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int M = W - 1;

  logic           s1_valid_reg;
  logic           s1_same_reg;
  logic           s1_sign_reg;
  logic [M-1:0]   s1_big_reg;
  logic [M-1:0]   s1_small_reg;

  logic           out_valid_reg;
  logic           ovf_reg;
  logic [W-1:0]   sum_reg;
  logic [CNT_W-1:0] ovf_cnt_reg;

  logic s2_adv;
  logic s1_adv;
  logic in_xfer;
  logic out_xfer;

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = s1_valid_reg && s2_adv;
  assign in_ready = !rst && (!s1_valid_reg || s2_adv);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_reg && out_ready;

  // Stage 1 operand classification
  logic         sa;
  logic         sb;
  logic [M-1:0] ma;
  logic [M-1:0] mb;
  logic         same_next;
  logic         sign_next;
  logic [M-1:0] big_next;
  logic [M-1:0] small_next;

  always_comb begin
    sa         = a[W-1];
    sb         = b[W-1] ^ op;
    ma         = a[M-1:0];
    mb         = b[M-1:0];
    same_next  = (sa == sb);
    big_next   = ma;
    small_next = mb;
    sign_next  = 1'b0;
    if (mb > ma) begin
      big_next   = mb;
      small_next = ma;
    end
    if (same_next) begin
      sign_next = sa;
    end else if (ma > mb) begin
      sign_next = sa;
    end else if (mb > ma) begin
      sign_next = sb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_same_reg  <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_big_reg   <= '0;
      s1_small_reg <= '0;
    end else if (in_xfer) begin
      s1_valid_reg <= 1'b1;
      s1_same_reg  <= same_next;
      s1_sign_reg  <= sign_next;
      s1_big_reg   <= big_next;
      s1_small_reg <= small_next;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2 magnitude arithmetic
  logic [M:0]   add_full;
  logic [M-1:0] diff;
  logic [M-1:0] mag_next;
  logic         res_sign_next;
  logic         ovf_next;

  always_comb begin
    add_full      = {1'b0, s1_big_reg} + {1'b0, s1_small_reg};
    diff          = s1_big_reg - s1_small_reg;
    ovf_next      = 1'b0;
    mag_next      = diff;
    res_sign_next = s1_sign_reg;
    if (s1_same_reg) begin
      ovf_next = add_full[M];
      mag_next = add_full[M-1:0];
`ifdef SM_ADD_PIPE_SAT_EN
      if (add_full[M]) begin
        mag_next = '1;
      end
`endif
    end
    // Canonical zero: never emit a negative zero, including a wrapped zero.
    if (mag_next == '0) begin
      res_sign_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      ovf_reg       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg <= {res_sign_next, mag_next};
        ovf_reg <= ovf_next;
      end
    end
  end

  // Overflow-event counter sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_reg <= '0;
    end else if (out_xfer && ovf_reg && !(&ovf_cnt_reg)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign ovf       = ovf_reg;
  assign ovf_cnt   = ovf_cnt_reg;

endmodule

// File: tb/tb_sm_add_pipe.sv
// Self-checking bench for sm_add_pipe: vector table, directed corner sequences and
// randomized traffic scored against an integer-arithmetic reference model.
module tb_sm_add_pipe;

  localparam int W = 16;
  localparam int CNT_W = 8;
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic op;
  logic out_valid;
  logic out_ready;
  logic [W-1:0] sum;
  logic ovf;
  logic [CNT_W-1:0] ovf_cnt;

  logic in_ready2;
  logic out_valid2;
  logic [W-1:0] sum2;
  logic ovf2;
  logic [1:0] ovf_cnt2;

  always #5 clk = ~clk;

  sm_add_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  sm_add_pipe #(.W(W), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
    .sum(sum2), .ovf(ovf2), .ovf_cnt(ovf_cnt2)
  );

  int checks = 0;
  int errors = 0;

  // Reference: signed integer arithmetic, then re-encode as sign-magnitude.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic o);
    longint va, vb, r, mag;
    logic neg, ov;
    va = x[W-1] ? -longint'(x[W-2:0]) : longint'(x[W-2:0]);
    vb = y[W-1] ? -longint'(y[W-2:0]) : longint'(y[W-2:0]);
    if (o) vb = -vb;
    r = va + vb;
    neg = (r < 0);
    mag = neg ? -r : r;
    ov = (mag > MAXMAG);
`ifdef SM_ADD_PIPE_SAT_EN
    if (ov) mag = MAXMAG;
`else
    mag = mag % (MAXMAG + 1);
`endif
    if (mag == 0) neg = 1'b0;
    ref_add = {ov, neg, mag[W-2:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  logic [W:0] exp_q[$];
  int cnt_model = 0;
  int n_out = 0;
  logic stalled_prev = 1'b0;
  logic [W-1:0] sum_prev;
  logic ovf_prev;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cnt_model = 0;
      stalled_prev = 1'b0;
    end else begin
      check("ovf_cnt_track", ovf_cnt, cnt_model);
      if (stalled_prev) begin
        check("stall_sum_hold", sum, sum_prev);
        check("stall_ovf_hold", ovf, ovf_prev);
        check("stall_valid_hold", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("sb_sum", sum, e[W-1:0]);
          check("sb_ovf", ovf, e[W]);
          if (ovf && cnt_model < (1 << CNT_W) - 1) cnt_model++;
        end
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, op));
      stalled_prev = out_valid && !out_ready;
      sum_prev = sum;
      ovf_prev = ovf;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents one pair and returns #1 after the edge that transfers it.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    int t;
    a = x; b = y; op = o; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vop;
    logic [W-1:0] esum;
    logic         eovf;
  } vec_t;

  vec_t vecs[13];
  logic [W-1:0] bp_a[6];
  logic [W-1:0] bp_b[6];

  initial begin
    int idx, t, cyc;
    logic saw_block;
    logic [W-1:0] ovsum_p, ovsum_n;
`ifdef SM_ADD_PIPE_SAT_EN
    ovsum_p = 16'h7FFF; ovsum_n = 16'hFFFF;
`else
    ovsum_p = 16'h0000; ovsum_n = 16'h0000;
`endif
    vecs[0]  = '{16'h8005, 16'h0003, 1'b0, 16'h8002, 1'b0};
    vecs[1]  = '{16'h0003, 16'h8005, 1'b0, 16'h8002, 1'b0};
    vecs[2]  = '{16'h8007, 16'h0007, 1'b0, 16'h0000, 1'b0};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{16'h0009, 16'h0009, 1'b1, 16'h0000, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, ovsum_p, 1'b1};
    vecs[6]  = '{16'hC000, 16'hC000, 1'b0, ovsum_n, 1'b1};
    vecs[7]  = '{16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0};
    vecs[8]  = '{16'h0005, 16'h8003, 1'b1, 16'h0008, 1'b0};
    vecs[9]  = '{16'h8005, 16'h8003, 1'b1, 16'h8002, 1'b0};
    vecs[10] = '{16'h0003, 16'h0005, 1'b1, 16'h8002, 1'b0};
    vecs[11] = '{16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[12] = '{16'h4000, 16'hC000, 1'b1, ovsum_p, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Vector table, one pair at a time, latency 2
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      send(vecs[i].va, vecs[i].vb, vecs[i].vop);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].esum);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].eovf);
      $display("vec %0d: a=%h b=%h op=%0d -> sum=%h ovf=%0d", i, vecs[i].va, vecs[i].vb,
               vecs[i].vop, sum, ovf);
    end
    @(posedge clk); #1;
`ifndef SM_ADD_PIPE_SAT_EN
    @(negedge clk);
    check("wrap_ovf_cnt", ovf_cnt, 3);
`endif

    // Backpressure: 6 pairs streamed, out_ready low for 3 cycles mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = W'(i * 3 + 1);
      bp_b[i] = W'(i + 16'h8000 + 2 * i);
    end
    idx = 0; saw_block = 1'b0; n_out = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 6);
      if (idx < 6) begin
        in_valid = 1'b1; a = bp_a[idx]; b = bp_b[idx]; op = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (!out_ready && !in_ready) saw_block = 1'b1;
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    check("bp_in_ready_dropped", saw_block, 1);
    check("bp_all_sent", idx, 6);
    check("bp_outputs", n_out, 6);
    $display("backpressure: %0d sent, %0d received", idx, n_out);

    // Counter saturation on the CNT_W=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(16'h7FFF, 16'h0001, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cnt2_step%0d", i), ovf_cnt2, (i + 1 < 3) ? i + 1 : 3);
      check($sformatf("cnt2_sum%0d", i), sum2, ovsum_p);
      $display("cnt2 step %0d: ovf_cnt=%0d", i, ovf_cnt2);
      @(posedge clk); #1;
    end

    // Reset with both stages full
    out_ready = 1'b0;
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ovf_cnt", ovf_cnt, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_in_ready2", in_ready2, 1);
    @(posedge clk); #1;
    send(16'h0002, 16'h0003, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("postrst_valid", out_valid, 1);
    check("postrst_sum", sum, 16'h0005);
    check("postrst_valid2", out_valid2, 1);
    check("postrst_ovf2", ovf2, 0);
    $display("post-reset: sum=%h", sum);
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra[W-2:0] = '1;
        1: ra[W-2:0] = '0;
        2: rb[W-2:0] = ra[W-2:0];
        default: ;
      endcase
      a = ra; b = rb; op = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    $display("random: drained, ovf_cnt=%0d", ovf_cnt);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
